// File: rtl/disp7seg_scan.sv
// disp7seg_scan: 4-digit multiplexed 7-segment scanner with frame-aligned capture and leading-zero blanking
module disp7seg_scan #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clocken,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [1:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  dps_q, dps_d;
  logic        blz_q, blz_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;
  logic        fs_q, fs_d;
  logic        wrap, blank;
  logic [3:0]  nib, onehot;
  // next digit, frame-boundary shadow capture and decode of the digit about to be lit
  always_comb begin
    wrap   = clocken && (idx_q == 2'd3);
    idx_d  = clocken ? idx_q + 2'd1 : idx_q;
    data_d = wrap ? data_in : data_q;
    dps_d  = wrap ? dp_in : dps_q;
    blz_d  = wrap ? blank_lz : blz_q;
    nib    = data_d[{idx_d, 2'b00} +: 4];
    onehot = 4'b0001 << idx_d;
    blank  = blz_d && ((idx_d == 2'd3) ? (data_d[15:12] == 4'h0) :
                       (idx_d == 2'd2) ? (data_d[15:8] == 8'h00) :
                       (idx_d == 2'd1) ? (data_d[15:4] == 12'h000) : 1'b0);
    seg_d  = !clocken ? seg_q : blank ? SEG_OFF : (SEG_ACTIVE_LOW ? HEX[nib] : ~HEX[nib]);
    dp_d   = !clocken ? dp_q : (blank || !dps_d[idx_d]) ? DP_OFF : ~DP_OFF;
    an_d   = !clocken ? an_q : (blank || !enable) ? AN_OFF : (AN_ACTIVE_LOW ? ~onehot : onehot);
    fs_d   = wrap;
  end
  // state and output registers; reset leaves every pin dark
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q  <= 2'd0;
      data_q <= 16'h0000;
      dps_q  <= 4'h0;
      blz_q  <= 1'b0;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      an_q   <= AN_OFF;
      fs_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      dps_q  <= dps_d;
      blz_q  <= blz_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      fs_q   <= fs_d;
    end
  end
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_disp7seg_scan.sv
// tb_disp7seg_scan: directed checks of scanning, frame capture, blanking, enable, bursts and reset
module tb_disp7seg_scan;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clocken = 1'b1;
  logic        enable = 1'b1;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  int total = 0;
  int bad = 0;

  disp7seg_scan dut (
    .clock(clock), .reset(reset), .clocken(clocken), .enable(enable), .blank_lz(blank_lz),
    .data_in(data_in), .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic strobe();
    @(negedge clock) clocken = 1'b1;
    @(negedge clock) clocken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clocken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an[%0d] got=%h exp=F", i, an); end
      total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg[%0d] got=%h exp=7F", i, seg); end
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp[%0d] got=%b exp=1", i, dp); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs[%0d] got=%b exp=0", i, frame_start); end
    end
    clocken = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] an_e [8] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    logic [6:0] seg_e [8] = '{7'h40, 7'h40, 7'h40, 7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
    logic       fs_e [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    data_in = 16'h1234;
    dp_in = 4'h0;
    for (int i = 0; i < 8; i++) begin
      strobe();
      total++; if (an !== an_e[i]) begin bad++; $display("FAIL scan_an[%0d] got=%h exp=%h", i, an, an_e[i]); end
      total++; if (seg !== seg_e[i]) begin bad++; $display("FAIL scan_seg[%0d] got=%h exp=%h", i, seg, seg_e[i]); end
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL scan_dp[%0d] got=%b exp=1", i, dp); end
      total++; if (frame_start !== fs_e[i]) begin bad++; $display("FAIL scan_fs[%0d] got=%b exp=%b", i, frame_start, fs_e[i]); end
      if (i == 3) begin
        @(negedge clock);
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL scan_fs_pulse got=%b exp=0", frame_start); end
        total++; if (seg !== 7'h19 || an !== 4'hE) begin bad++; $display("FAIL scan_hold got=%h/%h exp=19/E", seg, an); end
      end
    end
  endtask

  task automatic test_frame_sync();
    logic [3:0] an_e [6] = '{4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_e [6] = '{7'h24, 7'h79, 7'h21, 7'h46, 7'h03, 7'h08};
    logic       fs_e [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    strobe();
    total++; if (seg !== 7'h30 || an !== 4'hD) begin bad++; $display("FAIL sync_pre got=%h/%h exp=30/D", seg, an); end
    data_in = 16'hABCD;
    for (int i = 0; i < 6; i++) begin
      strobe();
      total++; if (an !== an_e[i]) begin bad++; $display("FAIL sync_an[%0d] got=%h exp=%h", i, an, an_e[i]); end
      total++; if (seg !== seg_e[i]) begin bad++; $display("FAIL sync_seg[%0d] got=%h exp=%h", i, seg, seg_e[i]); end
      total++; if (frame_start !== fs_e[i]) begin bad++; $display("FAIL sync_fs[%0d] got=%b exp=%b", i, frame_start, fs_e[i]); end
    end
  endtask

  task automatic test_blank();
    logic [15:0] d_e [3] = '{16'h0007, 16'h0070, 16'h0000};
    logic [3:0] an_e [12] = '{4'hE, 4'hF, 4'hF, 4'hF, 4'hE, 4'hD, 4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF};
    logic [6:0] seg_e [12] = '{7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h78, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic       dp_e [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    blank_lz = 1'b1;
    dp_in = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) data_in = d_e[i / 4];
      strobe();
      total++; if (an !== an_e[i]) begin bad++; $display("FAIL blank_an[%0d] got=%h exp=%h", i, an, an_e[i]); end
      total++; if (seg !== seg_e[i]) begin bad++; $display("FAIL blank_seg[%0d] got=%h exp=%h", i, seg, seg_e[i]); end
      total++; if (dp !== dp_e[i]) begin bad++; $display("FAIL blank_dp[%0d] got=%b exp=%b", i, dp, dp_e[i]); end
    end
  endtask

  task automatic test_enable();
    logic [3:0] an_e [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_e [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic       dp_e [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    blank_lz = 1'b0;
    data_in = 16'h1234;
    dp_in = 4'b0100;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe();
      total++; if (an !== an_e[i]) begin bad++; $display("FAIL en_an[%0d] got=%h exp=%h", i, an, an_e[i]); end
      total++; if (seg !== seg_e[i % 4]) begin bad++; $display("FAIL en_seg[%0d] got=%h exp=%h", i, seg, seg_e[i % 4]); end
      total++; if (dp !== dp_e[i % 4]) begin bad++; $display("FAIL en_dp[%0d] got=%b exp=%b", i, dp, dp_e[i % 4]); end
      total++; if (frame_start !== (i % 4 == 0)) begin bad++; $display("FAIL en_fs[%0d] got=%b exp=%b", i, frame_start, i % 4 == 0); end
      if (i == 3) enable = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] an_e [5] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD};
    int fs_cnt = 0;
    strobe();
    total++; if (an !== 4'hE) begin bad++; $display("FAIL burst_start got=%h exp=E", an); end
    @(negedge clock) clocken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 4) clocken = 1'b0;
      if (frame_start === 1'b1) fs_cnt++;
      total++; if (an !== an_e[i]) begin bad++; $display("FAIL burst_an[%0d] got=%h exp=%h", i, an, an_e[i]); end
    end
    @(negedge clock);
    if (frame_start === 1'b1) fs_cnt++;
    total++; if (fs_cnt !== 1) begin bad++; $display("FAIL burst_fs_count got=%0d exp=1", fs_cnt); end
    total++; if (seg !== 7'h30 || an !== 4'hD) begin bad++; $display("FAIL burst_end got=%h/%h exp=30/D", seg, an); end
  endtask

  task automatic test_mid_reset();
    logic [3:0] an_e [4] = '{4'hD, 4'hB, 4'h7, 4'hE};
    logic [6:0] seg_e [4] = '{7'h40, 7'h40, 7'h40, 7'h19};
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    total++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%h/%h/%b/%b exp=F/7F/1/0", an, seg, dp, frame_start);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe();
      total++; if (an !== an_e[i]) begin bad++; $display("FAIL mr_an[%0d] got=%h exp=%h", i, an, an_e[i]); end
      total++; if (seg !== seg_e[i]) begin bad++; $display("FAIL mr_seg[%0d] got=%h exp=%h", i, seg, seg_e[i]); end
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL mr_dp[%0d] got=%b exp=1", i, dp); end
      total++; if (frame_start !== (i == 3)) begin bad++; $display("FAIL mr_fs[%0d] got=%b exp=%b", i, frame_start, i == 3); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_sync();
    test_blank();
    test_enable();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
